// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU: opcodes, FSM states,
// and instruction field geometry.
package acc_cpu_pkg;

  localparam int OPC_W     = 4;
  localparam int MODE_W    = 1;
  localparam int FIELD_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OPC_W-1:0] OP_STR  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JC   = 4'hA;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'hB;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Opcodes that write the accumulator and the flags.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_LOAD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: produces the new accumulator value and Z/C flags.
// C passes through unchanged for LOAD; logic ops clear it.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] op_b,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] sum;

  always_comb begin
    result = acc;
    c      = c_in;
    sum    = '0;
    case (opcode)
      OP_LOAD: result = op_b;
      OP_ADD: begin
        sum    = {1'b0, acc} + {1'b0, op_b};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = acc - op_b;
        c      = (acc < op_b);
      end
      OP_AND: begin
        result = acc & op_b;
        c      = 1'b0;
      end
      OP_OR: begin
        result = acc | op_b;
        c      = 1'b0;
      end
      OP_XOR: begin
        result = acc ^ op_b;
        c      = 1'b0;
      end
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core: FETCH -> DECODE -> EXEC, three cycles per
// instruction, with a register file, Z/C flags, jumps, OUT strobe and HALTED.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_FETCH  | imem_addr = pc presented; memory responds next cycle
// ST_DECODE | IR captures imem_rdata
// ST_EXEC   | IR executes; pc/acc/flags/regs/out update at end of cycle
// ST_HALTED | absorbing after HLT; everything frozen until reset
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  parameter  int PC_W     = 8,
  localparam int INSTR_W  = OPC_W + MODE_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               halted,
  output logic [DATA_W-1:0]  acc_dbg
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   acc;
  logic                z_flag, c_flag;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [OPC_W-1:0]    opcode;
  logic                mode;
  logic [DATA_W-1:0]   field;
  logic [IDX_W-1:0]    reg_idx;
  logic [DATA_W-1:0]   op_b;
  logic [PC_W-1:0]     jump_tgt;
  logic                jump_taken;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_z, alu_c;

  logic                ir_load;
  logic                exec_en;

  assign opcode   = ir[INSTR_W-1 -: OPC_W];
  assign mode     = ir[DATA_W];
  assign field    = ir[FIELD_LSB +: DATA_W];
  assign reg_idx  = field[IDX_W-1:0];
  assign op_b     = mode ? regs[reg_idx] : field;
  // Size cast zero-extends or truncates the field to the pc width.
  assign jump_tgt = PC_W'(field);

  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = z_flag;
      OP_JC:   jump_taken = c_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  acc_cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .acc    (acc),
    .op_b   (op_b),
    .opcode (opcode),
    .c_in   (c_flag),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = (opcode == OP_HLT) ? ST_HALTED : ST_FETCH;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    ir_load = 1'b0;
    exec_en = 1'b0;
    halted  = 1'b0;
    case (state)
      ST_DECODE: ir_load = 1'b1;
      ST_EXEC:   exec_en = 1'b1;
      ST_HALTED: halted  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (ir_load) begin
        ir <= imem_rdata;
      end
      if (exec_en) begin
        if (is_alu_op(opcode)) begin
          acc    <= alu_result;
          z_flag <= alu_z;
          c_flag <= alu_c;
        end
        if (opcode == OP_STR) begin
          regs[reg_idx] <= acc;
        end
        if (opcode == OP_OUT) begin
          out_data  <= acc;
          out_valid <= 1'b1;
        end
        // HLT leaves pc pointing at itself.
        if (opcode != OP_HLT) begin
          pc <= jump_taken ? jump_tgt : pc + PC_W'(1);
        end
      end
    end
  end

  assign imem_addr = pc;
  assign acc_dbg   = acc;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: instruction-level reference model stepped every third
// cycle, compared against the DUT every cycle, plus directed literal checks.
module tb_acc_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  imem_addr;
  logic [12:0] imem_rdata = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        halted;
  logic [7:0]  acc_dbg;

  acc_cpu_core dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halted     (halted),
    .acc_dbg    (acc_dbg)
  );

  always #5 clk = ~clk;

  logic [12:0] imem [256];
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;
  bit chk_on   = 0;

  // Architectural model state
  int m_pc, m_acc, m_z, m_c, m_out, m_ov, m_halt, m_phase;
  int m_regs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] ins(input int op, input int md, input int f);
    return {op[3:0], md[0], f[7:0]};
  endfunction

  task automatic model_exec(input logic [12:0] w);
    int op, md, f, b, s;
    op = int'(w[12:9]);
    md = int'(w[8]);
    f  = int'(w[7:0]);
    b  = md ? m_regs[f % 4] : f;
    case (op)
      1: m_acc = b;
      2: begin s = m_acc + b; m_c = (s > 255) ? 1 : 0; m_acc = s % 256; end
      3: begin m_c = (m_acc < b) ? 1 : 0; m_acc = (m_acc - b + 256) % 256; end
      4: begin m_acc = m_acc & b; m_c = 0; end
      5: begin m_acc = m_acc | b; m_c = 0; end
      6: begin m_acc = m_acc ^ b; m_c = 0; end
      7: m_regs[f % 4] = m_acc;
      11: begin m_out = m_acc; m_ov = 1; end
      15: m_halt = 1;
      default: ;
    endcase
    if (op >= 1 && op <= 6) m_z = (m_acc == 0) ? 1 : 0;
    if (op == 8 || (op == 9 && m_z == 1) || (op == 10 && m_c == 1)) m_pc = f;
    else if (op != 15) m_pc = (m_pc + 1) % 256;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_out = 0; m_ov = 0;
      m_halt = 0; m_phase = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
    end else begin
      m_ov = 0;
      if (m_halt == 0) begin
        if (m_phase == 2) begin
          m_phase = 0;
          model_exec(imem[m_pc]);
        end else begin
          m_phase++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("acc_dbg",   32'(acc_dbg),   32'(m_acc));
      chk("out_data",  32'(out_data),  32'(m_out));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("halted",    32'(halted),    32'(m_halt));
      if (out_valid === 1'b1) n_pulse++;
    end
  end

  task automatic fill(input logic [12:0] w);
    for (int i = 0; i < 256; i++) imem[i] = w;
  endtask

  task automatic start_prog();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic hold_reset();
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_to_halt(input string name, input int max, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (halted !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, halted=%0b after %0d cycles, required 1", name, halted, cyc);
    end
  endtask

  initial begin
    int cyc, p0;
    fill(ins(15, 0, 0));
    #1 reset = 1'b1;
    #2 chk_on = 1;
    @(negedge clk);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_acc", 32'(acc_dbg), 32'h0);
    chk("rst_out", {22'h0, out_data, out_valid, halted}, 32'h0);

    // 1: LOAD #5; ADD #3; OUT; HLT
    imem[0] = ins(1, 0, 5); imem[1] = ins(2, 0, 3);
    imem[2] = ins(11, 0, 0); imem[3] = ins(15, 0, 0);
    p0 = n_pulse;
    start_prog();
    run_to_halt("t1_halt", 60, cyc);
    chk("t1_cycles", 32'(cyc), 32'd12);
    chk("t1_out", 32'(out_data), 32'h8);
    repeat (10) @(negedge clk);
    chk("t1_pc_frozen", 32'(imem_addr), 32'h3);
    chk("t1_pulses", 32'(n_pulse - p0), 32'd1);

    // 2: carry/zero then borrow, observed through conditional jumps
    hold_reset();
    fill(ins(15, 0, 0));
    imem[0] = ins(1, 0, 8'hFF); imem[1] = ins(2, 0, 1); imem[2] = ins(11, 0, 0);
    imem[3] = ins(9, 0, 5);     imem[5] = ins(10, 0, 7);
    imem[7] = ins(3, 0, 1);     imem[8] = ins(11, 0, 0);
    imem[9] = ins(10, 0, 8'h0B); imem[8'h0B] = ins(9, 0, 8'h0D);
    p0 = n_pulse;
    start_prog();
    run_to_halt("t2_halt", 100, cyc);
    chk("t2_pc", 32'(imem_addr), 32'h0C);
    chk("t2_acc", 32'(acc_dbg), 32'hFF);
    chk("t2_out", 32'(out_data), 32'hFF);
    chk("t2_pulses", 32'(n_pulse - p0), 32'd2);

    // 3: register store and aliased register read
    hold_reset();
    fill(ins(15, 0, 0));
    imem[0] = ins(1, 0, 8'h0A); imem[1] = ins(7, 0, 2);
    imem[2] = ins(1, 0, 0);     imem[3] = ins(2, 1, 8'h06);
    start_prog();
    run_to_halt("t3_halt", 60, cyc);
    chk("t3_acc", 32'(acc_dbg), 32'h0A);
    chk("t3_pc", 32'(imem_addr), 32'h4);

    // 4: JZ taken then not taken
    hold_reset();
    fill(ins(15, 0, 0));
    imem[0] = ins(1, 0, 0); imem[1] = ins(9, 0, 8'h10);
    imem[8'h10] = ins(1, 0, 1); imem[8'h11] = ins(9, 0, 8'h20);
    start_prog();
    run_to_halt("t4_halt", 60, cyc);
    chk("t4_pc", 32'(imem_addr), 32'h12);
    chk("t4_acc", 32'(acc_dbg), 32'h1);

    // 5: pc wraps from 0xFF to 0x00
    hold_reset();
    fill(ins(15, 0, 0));
    imem[0] = ins(8, 1, 8'hFF); imem[8'hFF] = ins(0, 0, 0);
    start_prog();
    repeat (3) @(negedge clk);
    chk("t5_jmp", 32'(imem_addr), 32'hFF);
    repeat (3) @(negedge clk);
    chk("t5_wrap", 32'(imem_addr), 32'h0);

    // 6: reset during EXEC of an ADD after flags were set
    hold_reset();
    fill(ins(15, 0, 0));
    imem[0] = ins(1, 0, 8'hFE); imem[1] = ins(2, 0, 2); imem[2] = ins(2, 0, 5);
    start_prog();
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_acc", 32'(acc_dbg), 32'h0);
    chk("t6_pc", 32'(imem_addr), 32'h0);
    fill(ins(15, 0, 0));
    imem[0] = ins(9, 0, 4); imem[1] = ins(10, 0, 4); imem[2] = ins(11, 0, 0);
    p0 = n_pulse;
    @(negedge clk);
    start_prog();
    run_to_halt("t6_halt", 60, cyc);
    chk("t6_flags_clear_pc", 32'(imem_addr), 32'h3);
    chk("t6_pulses", 32'(n_pulse - p0), 32'd1);

    // Random programs with occasional mid-run resets
    for (int r = 0; r < 10; r++) begin
      hold_reset();
      for (int a = 0; a < 256; a++) begin
        int op;
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 7) != 0) op = 0;
        imem[a] = ins(op, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      end
      start_prog();
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 199) == 0) begin
          #2 reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
